// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared segment codes and scan defaults for seven_seg
package seven_seg_pkg;

  localparam int REFRESH_BITS_DEFAULT = 18;

  typedef logic [6:0] seg_t;  // {a,b,c,d,e,f,g}, active-low

  localparam seg_t SEG_0     = 7'b0000001;
  localparam seg_t SEG_1     = 7'b1001111;
  localparam seg_t SEG_2     = 7'b0010010;
  localparam seg_t SEG_3     = 7'b0000110;
  localparam seg_t SEG_4     = 7'b1001100;
  localparam seg_t SEG_5     = 7'b0100100;
  localparam seg_t SEG_6     = 7'b0100000;
  localparam seg_t SEG_7     = 7'b0001111;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0000100;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b1100000;
  localparam seg_t SEG_C     = 7'b0110001;
  localparam seg_t SEG_D     = 7'b1000010;
  localparam seg_t SEG_E     = 7'b0110000;
  localparam seg_t SEG_F     = 7'b0111000;
  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/seven_seg_hex_to_seg.sv
// rtl/seven_seg_hex_to_seg.sv - combinational hex digit to active-low abcdefg decoder
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (hex_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg.sv
// rtl/seven_seg.sv - four-digit multiplexed seven-segment scanner with registered outputs
module seven_seg
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_BITS = REFRESH_BITS_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic [3:0] in3,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       dp,
  output logic [3:0] an
);

  localparam logic [REFRESH_BITS-1:0] CNT_ONE = REFRESH_BITS'(1);

  logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
  logic [1:0]              idx;
  logic [3:0]              hex_sel;
  seg_t                    seg_dec, seg_q, seg_d;
  logic [3:0]              an_q, an_d;

  // Top two counter bits pick the digit, so each digit dwells 2^(REFRESH_BITS-2) clocks.
  assign idx = cnt_q[REFRESH_BITS-1 -: 2];

  always_comb begin
    hex_sel = in0;
    case (idx)
      2'd0: hex_sel = in0;
      2'd1: hex_sel = in1;
      2'd2: hex_sel = in2;
      2'd3: hex_sel = in3;
      default: hex_sel = in0;
    endcase
  end

  hex_to_seg u_hex_to_seg (
    .hex_i (hex_sel),
    .seg_o (seg_dec)
  );

  always_comb begin
    cnt_d = cnt_q + CNT_ONE;
    an_d  = ~(4'b0001 << idx);
    seg_d = seg_dec;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      an_q  <= AN_OFF;
      seg_q <= SEG_BLANK;
    end else begin
      cnt_q <= cnt_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an                  = an_q;
  assign {a, b, c, d, e, f, g} = seg_q;
  assign dp                  = 1'b1;

endmodule

// File: tb/tb_seven_seg.sv
// tb/tb_seven_seg.sv - directed self-checking bench for seven_seg with a 4-bit scan counter
module tb_seven_seg;

  logic       clock;
  logic       reset;
  logic [3:0] in_v [4];
  logic [3:0] in0, in1, in2, in3;
  logic       a, b, c, d, e, f, g, dp;
  logic [3:0] an;

  int n_checks;
  int n_pass;
  int edges;

  logic [6:0] exp_seg [16];

  assign in0 = in_v[0];
  assign in1 = in_v[1];
  assign in2 = in_v[2];
  assign in3 = in_v[3];

  seven_seg #(.REFRESH_BITS(4)) dut (
    .clock (clock),
    .reset (reset),
    .in0   (in0),
    .in1   (in1),
    .in2   (in2),
    .in3   (in3),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .e     (e),
    .f     (f),
    .g     (g),
    .dp    (dp),
    .an    (an)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    edges++;
    @(negedge clock);
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_an"}, {28'd0, an}, 32'hF);
    check({tag, "_seg"}, {25'd0, a, b, c, d, e, f, g}, 32'h7F);
    check({tag, "_dp"}, {31'd0, dp}, 32'd1);
  endtask

  // Edge j after reset release shows digit ((j-1)/4) mod 4.
  task automatic check_scan(input string tag);
    int         dig;
    logic [3:0] ean;
    dig = ((edges - 1) / 4) % 4;
    ean = ~(4'b0001 << dig);
    check({tag, "_an"}, {28'd0, an}, {28'd0, ean});
    check({tag, "_seg"}, {25'd0, a, b, c, d, e, f, g}, {25'd0, exp_seg[in_v[dig]]});
    check({tag, "_dp"}, {31'd0, dp}, 32'd1);
  endtask

  task automatic run_frame(input string tag);
    for (int i = 0; i < 16; i++) begin
      tick();
      check_scan(tag);
    end
  endtask

  initial begin
    exp_seg = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    n_checks = 0;
    n_pass   = 0;
    edges    = 0;
    reset    = 1'b0;
    for (int k = 0; k < 4; k++) in_v[k] = 4'h0;

    // Held reset: blank for 100 ns regardless of clock
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check_blank("reset_hold");
    end

    reset = 1'b1;
    edges = 0;
    tick();
    check("first_an", {28'd0, an}, 32'hE);
    check("first_seg", {25'd0, a, b, c, d, e, f, g}, {25'd0, 7'b0000001});
    for (int i = 0; i < 15; i++) begin
      tick();
      check_scan("zeros");
    end

    in_v[0] = 4'h0; in_v[1] = 4'h1; in_v[2] = 4'h0; in_v[3] = 4'h5;
    run_frame("v0105");

    in_v[0] = 4'h4; in_v[1] = 4'h9; in_v[2] = 4'h9; in_v[3] = 4'h9;
    run_frame("v4999");

    // Sweep in0 while digit 0 is on; next edge index edges+1 must fall in digit 0
    for (int v = 0; v < 16; v++) begin
      for (int w = 0; w < 16 && ((edges / 4) % 4) != 0; w++) tick();
      check("sweep_align", {31'd0, ((edges / 4) % 4) == 0}, 32'd1);
      in_v[0] = v[3:0];
      tick();
      check("sweep_an", {28'd0, an}, 32'hE);
      check("sweep_seg", {25'd0, a, b, c, d, e, f, g}, {25'd0, exp_seg[v]});
    end

    in_v[0] = 4'h7; in_v[1] = 4'hA; in_v[2] = 4'hC; in_v[3] = 4'hF;
    for (int w = 0; w < 16 && (((edges - 1) / 4) % 4) != 2; w++) tick();
    check_scan("pre_reset");
    check("pre_reset_dig2", {28'd0, an}, 32'hB);

    #2 reset = 1'b0;
    #1 check_blank("async_reset");
    repeat (2) @(negedge clock);
    check_blank("reset_mid");

    reset = 1'b1;
    edges = 0;
    tick();
    check("restart_an", {28'd0, an}, 32'hE);
    check("restart_seg", {25'd0, a, b, c, d, e, f, g}, {25'd0, 7'b0001111});
    for (int i = 0; i < 15; i++) begin
      tick();
      check_scan("restart");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
